// File: rtl/gearbox_tx_66b_param.sv
`default_nettype none
// ============================================================================
// Module   : gearbox_tx_66b_param
// Purpose  : TX gearbox packing 64b/66b blocks (2b header + 64b payload) into
//            a continuous DATA_W-bit word stream (DATA_W = 32 or 64). A 33-step
//            sequence counter pauses input acceptance once per period so that
//            the 2 extra header bits per block drain out of the storage.
// Options  : GBX_EXT_SEQ_EN - sequence taken from sequence_i instead of the
//            internal counter; pause timing then belongs to the caller.
// Revision : 1.0 - initial release
// ============================================================================
module gearbox_tx_66b_param #(
  parameter int DATA_W  = 32,
  parameter int SEQ_MAX = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
`ifdef GBX_EXT_SEQ_EN
  input  logic [5:0]        sequence_i,
`endif
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        head_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [5:0]        sequence_o,
  output logic [DATA_W-1:0] data_o,
  output logic              underrun_o
);

  // Storage holds the unsent residual plus one freshly aligned word.
  localparam int              SW        = 2 * DATA_W + 2;
  localparam int              WW        = DATA_W + 2;
  localparam int              CNT_W     = 9;
  localparam logic [CNT_W-1:0] C_DW     = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] C_SW     = CNT_W'(SW);
  localparam logic [5:0]      C_SEQ_MAX = 6'(SEQ_MAX);
  localparam logic            IS64      = (DATA_W == 64);

  generate
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
      $error("gearbox_tx_66b_param: DATA_W must be 32 or 64");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Sequence source
  // --------------------------------------------------------------------------
  logic [5:0] seq_cur;

`ifdef GBX_EXT_SEQ_EN
  assign seq_cur = sequence_i;
`else
  logic [5:0] seq_q;
  logic [5:0] seq_d;

  assign seq_d = (seq_q == C_SEQ_MAX) ? 6'd0 : seq_q + 6'd1;

  // Free-running sequence counter, wraps after SEQ_MAX and never stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) seq_q <= '0;
    else          seq_q <= seq_d;
  end

  assign seq_cur = seq_q;
`endif

  // --------------------------------------------------------------------------
  // Handshake, sequence output, underrun flag and half-block phase
  // --------------------------------------------------------------------------
  logic       ready_q;
  logic       underrun_q;
  logic       phase_q;
  logic [5:0] seqo_q;

  // ready_o and sequence_o are both registered from seq_cur so they stay
  // aligned: ready_o is low exactly while sequence_o shows SEQ_MAX.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q    <= 1'b0;
      seqo_q     <= '0;
      underrun_q <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      ready_q    <= (seq_cur != C_SEQ_MAX);
      seqo_q     <= seq_cur;
      underrun_q <= ready_q & ~valid_i;
      if (ready_q && !IS64) phase_q <= ~phase_q;
    end
  end

  // --------------------------------------------------------------------------
  // Alignment stage: form the accepted word with its header (if any)
  // --------------------------------------------------------------------------
  logic              hdr_take;
  logic [DATA_W-1:0] data_eff;
  logic [1:0]        head_eff;
  logic [WW-1:0]     word_d;
  logic [WW-1:0]     a_word_q;
  logic              a_hdr_q;
  logic              a_act_q;

  // On underrun the slot is still consumed: zero payload, illegal header 00.
  assign hdr_take = IS64 | ~phase_q;
  assign data_eff = valid_i ? data_i : '0;
  assign head_eff = valid_i ? head_i : 2'b00;
  assign word_d   = hdr_take ? {head_eff, data_eff} : {data_eff, 2'b00};

  // Capture the accepted word left-aligned together with its bit length flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_word_q <= '0;
      a_hdr_q  <= 1'b0;
      a_act_q  <= 1'b0;
    end else begin
      a_act_q <= ready_q;
      if (ready_q) begin
        a_word_q <= word_d;
        a_hdr_q  <= hdr_take;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage stage: append new bits behind the residual, peel off one word
  // --------------------------------------------------------------------------
  logic [SW-1:0]     sto_q;
  logic [SW-1:0]     sto_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [SW-1:0]     new_al;
  logic [SW-1:0]     merged;
  logic [CNT_W-1:0]  avail;
  logic [DATA_W-1:0] out_d;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] data_q;

  // Merge the aligned word into storage and emit the oldest DATA_W bits once
  // enough are present; until then zeros go out and the bits are kept.
  always_comb begin
    new_al = '0;
    avail  = cnt_q;
    if (a_act_q) begin
      new_al = {a_word_q, {DATA_W{1'b0}}} >> cnt_q;
      avail  = cnt_q + (a_hdr_q ? C_DW + 9'd2 : C_DW);
    end
    merged = sto_q | new_al;
    // Only reachable if an external sequence skips its pauses.
    if (avail > C_SW) avail = C_SW;
    out_d = '0;
    sto_d = merged;
    cnt_d = avail;
    if (avail >= C_DW) begin
      out_d = merged[SW-1 -: DATA_W];
      sto_d = merged << DATA_W;
      cnt_d = avail - C_DW;
    end
  end

  // Storage, bit count and the two output word registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sto_q  <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      data_q <= '0;
    end else begin
      sto_q  <= sto_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      data_q <= out_q;
    end
  end

  assign ready_o    = ready_q;
  assign sequence_o = seqo_q;
  assign data_o     = data_q;
  assign underrun_o = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_gearbox_tx_66b_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_gearbox_tx_66b_param
// Purpose  : Self-checking bench for gearbox_tx_66b_param, 64- and 32-bit
//            instances side by side. Accepted blocks are pushed as a bit
//            queue; every emitted word pops DATA_W bits and is compared.
//            With GBX_EXT_SEQ_EN defined the bench drives sequence_i itself.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gearbox_tx_66b_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [63:0] d64 = '0;
  logic [1:0]  h64 = '0;
  logic        v64 = 1'b0;
  logic        rdy64, und64;
  logic [5:0]  seq64;
  logic [63:0] q64;
  logic [31:0] d32 = '0;
  logic [1:0]  h32 = '0;
  logic        v32 = 1'b0;
  logic        rdy32, und32;
  logic [5:0]  seq32;
  logic [31:0] q32;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef GBX_EXT_SEQ_EN
  logic [5:0] ext_seq;
  // External sequence generator: 0..32 then wrap, restarts on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ext_seq <= 6'd0;
    else        ext_seq <= (ext_seq == 6'd32) ? 6'd0 : ext_seq + 6'd1;
  end
`endif

  gearbox_tx_66b_param #(.DATA_W(64), .SEQ_MAX(32)) dut64 (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
`ifdef GBX_EXT_SEQ_EN
    .sequence_i (ext_seq),
`endif
    .data_i     (d64),
    .head_i     (h64),
    .valid_i    (v64),
    .ready_o    (rdy64),
    .sequence_o (seq64),
    .data_o     (q64),
    .underrun_o (und64)
  );

  gearbox_tx_66b_param #(.DATA_W(32), .SEQ_MAX(32)) dut32 (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
`ifdef GBX_EXT_SEQ_EN
    .sequence_i (ext_seq),
`endif
    .data_i     (d32),
    .head_i     (h32),
    .valid_i    (v32),
    .ready_o    (rdy32),
    .sequence_o (seq32),
    .data_o     (q32),
    .underrun_o (und32)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  bit bq64[$];
  bit bq32[$];
  int cyc     = 0;
  int first64 = -1;
  int first32 = -1;
  int acc32   = 0;
  bit ph32    = 1'b0;
  bit eu64    = 1'b0;
  bit eu32    = 1'b0;

  // Record accepted words as expected bitstream, in transmission order.
  always @(posedge clk or negedge rst_n) begin : sb_push
    logic [65:0] w;
    logic [1:0]  hh;
    logic [31:0] dd;
    if (!rst_n) begin
      cyc = 0; first64 = -1; first32 = -1; acc32 = 0; ph32 = 1'b0;
      eu64 = 1'b0; eu32 = 1'b0;
      bq64.delete(); bq32.delete();
    end else begin
      cyc++;
      eu64 = rdy64 && !v64;
      eu32 = rdy32 && !v32;
      if (rdy64) begin
        if (first64 < 0) first64 = cyc;
        w = v64 ? {h64, d64} : 66'd0;
        for (int i = 65; i >= 0; i--) bq64.push_back(w[i]);
      end
      if (rdy32) begin
        if (first32 < 0) first32 = cyc;
        hh = v32 ? h32 : 2'b00;
        dd = v32 ? d32 : 32'd0;
        if (!ph32) begin
          bq32.push_back(hh[1]);
          bq32.push_back(hh[0]);
        end
        for (int i = 31; i >= 0; i--) bq32.push_back(dd[i]);
        ph32 = !ph32;
        acc32++;
      end
    end
  end

  // Compare every emitted word and the underrun flag against the model.
  always @(negedge clk) begin : sb_pop
    logic [63:0] e64;
    logic [31:0] e32;
    if (rst_n) begin
      if (first64 >= 0 && cyc >= first64 + 2) begin
        n_chk++;
        if (bq64.size() < 64) begin
          n_fail++;
          $display("FAIL sb64_underflow: got %0d queued bits required 64 (cyc %0d)", bq64.size(), cyc);
        end else begin
          for (int i = 63; i >= 0; i--) e64[i] = bq64.pop_front();
          if (q64 !== e64) begin
            n_fail++;
            $display("FAIL sb64_data: got %h expected %h (cyc %0d)", q64, e64, cyc);
          end
        end
      end else begin
        n_chk++;
        if (q64 !== 64'd0) begin
          n_fail++;
          $display("FAIL sb64_idle: got %h expected 0 (cyc %0d)", q64, cyc);
        end
      end
      if (first32 >= 0 && cyc >= first32 + 2) begin
        n_chk++;
        if (bq32.size() < 32) begin
          n_fail++;
          $display("FAIL sb32_underflow: got %0d queued bits required 32 (cyc %0d)", bq32.size(), cyc);
        end else begin
          for (int i = 31; i >= 0; i--) e32[i] = bq32.pop_front();
          if (q32 !== e32) begin
            n_fail++;
            $display("FAIL sb32_data: got %h expected %h (cyc %0d)", q32, e32, cyc);
          end
        end
      end else begin
        n_chk++;
        if (q32 !== 32'd0) begin
          n_fail++;
          $display("FAIL sb32_idle: got %h expected 0 (cyc %0d)", q32, cyc);
        end
      end
      n_chk++;
      if (und64 !== eu64 || und32 !== eu32) begin
        n_fail++;
        $display("FAIL sb_underrun: got %b/%b expected %b/%b (cyc %0d)", und64, und32, eu64, eu32, cyc);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (no checking)
  // --------------------------------------------------------------------------
  task automatic drive_rand();
    v64 = 1'b1; d64 = {$urandom(), $urandom()}; h64 = 2'($urandom_range(1, 2));
    v32 = 1'b1; d32 = $urandom();               h32 = 2'($urandom_range(1, 2));
  endtask

  // Returns on the negedge where reset is released.
  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; drive_rand();
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; drive_rand();
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0; drive_rand();
    #1;
    n_chk++; if (q64 !== 64'd0)  begin n_fail++; $display("FAIL reset_data64: got %h expected 0", q64); end
    n_chk++; if (q32 !== 32'd0)  begin n_fail++; $display("FAIL reset_data32: got %h expected 0", q32); end
    n_chk++; if (rdy64 !== 1'b0 || rdy32 !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b/%b expected 0/0", rdy64, rdy32); end
    n_chk++; if (seq64 !== 6'd0 || seq32 !== 6'd0) begin n_fail++; $display("FAIL reset_seq: got %0d/%0d expected 0/0", seq64, seq32); end
    n_chk++; if (und64 !== 1'b0 || und32 !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b/%b expected 0/0", und64, und32); end
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; drive_rand();
  endtask

  // Must be entered on the reset-release negedge.
  task automatic test_pattern64(input string tag);
    drive_rand(); h64 = 2'b01; d64 = '1;
    n_chk++; if (rdy64 !== 1'b0) begin n_fail++; $display("FAIL %s_ready_k0: got %b expected 0", tag, rdy64); end
    @(negedge clk); drive_rand(); h64 = 2'b01; d64 = '1;
    n_chk++; if (rdy64 !== 1'b1) begin n_fail++; $display("FAIL %s_ready_k1: got %b expected 1", tag, rdy64); end
    @(negedge clk); drive_rand(); h64 = 2'b10; d64 = '0;
    @(negedge clk); drive_rand();
    @(negedge clk); drive_rand();
    n_chk++; if (q64 !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL %s_word0: got %h expected 7fffffffffffffff", tag, q64); end
    @(negedge clk); drive_rand();
    n_chk++; if (q64 !== 64'hE000_0000_0000_0000) begin n_fail++; $display("FAIL %s_word1: got %h expected e000000000000000", tag, q64); end
  endtask

  task automatic test_seq_ready();
    logic [5:0] es;
    logic       er;
    do_reset();
    n_chk++; if (seq64 !== 6'd0 || rdy64 !== 1'b0) begin n_fail++; $display("FAIL seq_k0: got %0d/%b expected 0/0", seq64, rdy64); end
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk); drive_rand();
      es = 6'((k - 1) % 33);
      er = (es != 6'd32);
      n_chk++; if (seq64 !== es || rdy64 !== er) begin n_fail++; $display("FAIL seq64_k%0d: got %0d/%b expected %0d/%b", k, seq64, rdy64, es, er); end
      n_chk++; if (seq32 !== es || rdy32 !== er) begin n_fail++; $display("FAIL seq32_k%0d: got %0d/%b expected %0d/%b", k, seq32, rdy32, es, er); end
      n_chk++; if (und64 !== 1'b0) begin n_fail++; $display("FAIL seq_underrun_k%0d: got %b expected 0", k, und64); end
    end
  endtask

  task automatic test_random32();
    int start;
    start = acc32;
    repeat (1100) begin @(negedge clk); drive_rand(); end
    n_chk++;
    if ((acc32 - start) / 2 < 512) begin
      n_fail++; $display("FAIL random32_blocks: got %0d expected >= 512", (acc32 - start) / 2);
    end
  endtask

  task automatic test_underrun();
    int t;
    t = 0;
    while (!(rdy64 === 1'b1 && seq64 == 6'd10) && t < 100) begin @(negedge clk); drive_rand(); t++; end
    n_chk++;
    if (t >= 100) begin
      n_fail++; $display("FAIL underrun_wait: got timeout expected seq 10");
    end else begin
      v64 = 1'b0; v32 = 1'b0;
      @(negedge clk); drive_rand();
      n_chk++; if (und64 !== 1'b1 || und32 !== 1'b1) begin n_fail++; $display("FAIL underrun_pulse: got %b/%b expected 1/1", und64, und32); end
      @(negedge clk); drive_rand();
      n_chk++; if (und64 !== 1'b0 || und32 !== 1'b0) begin n_fail++; $display("FAIL underrun_single: got %b/%b expected 0/0", und64, und32); end
    end
    t = 0;
    while (rdy64 !== 1'b0 && t < 100) begin @(negedge clk); drive_rand(); t++; end
    n_chk++;
    if (t >= 100) begin
      n_fail++; $display("FAIL pause_wait: got timeout expected ready low");
    end else begin
      v64 = 1'b0; v32 = 1'b0;
      @(negedge clk); drive_rand();
      n_chk++; if (und64 !== 1'b0 || und32 !== 1'b0) begin n_fail++; $display("FAIL pause_no_underrun: got %b/%b expected 0/0", und64, und32); end
    end
    repeat (80) begin @(negedge clk); drive_rand(); end
  endtask

  task automatic test_reset_mid();
    int t;
    t = 0;
    while (seq64 != 6'd17 && t < 100) begin @(negedge clk); drive_rand(); t++; end
    n_chk++;
    if (t >= 100) begin
      n_fail++; $display("FAIL reset_mid_wait: got timeout expected seq 17");
    end else begin
      @(posedge clk); #2; rst_n = 1'b0; #1;
      n_chk++; if (q64 !== 64'd0 || q32 !== 32'd0) begin n_fail++; $display("FAIL reset_mid_data: got %h/%h expected 0/0", q64, q32); end
      n_chk++; if (rdy64 !== 1'b0 || seq64 !== 6'd0) begin n_fail++; $display("FAIL reset_mid_ctrl: got %b/%0d expected 0/0", rdy64, seq64); end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      test_pattern64("restart");
      repeat (40) begin @(negedge clk); drive_rand(); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_rand();
    test_reset();
    test_pattern64("pattern");
    test_seq_ready();
    test_random32();
    test_underrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
